stepper_move_ctrl: RTL and testbench

Upstream motion controller for the stepper phase sequencer. It accepts move commands (step count, direction) over a valid/ready handshake and emits one-cycle step pulses plus a direction level. Step pulses follow a linear trapezoidal period ramp: accelerate from START_DIV to MIN_DIV, cruise, then decelerate symmetrically to stop. The phase sequencer advances one half-step per step pulse in the direction given by dir; this block also tracks absolute position.

---
 rtl/stepper_move_ctrl.sv | 141 ++++++++++++++
 tb/tb_stepper_move_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_move_ctrl.sv
// Move controller for the stepper phase sequencer: accepts (steps, dir) commands
// and emits step pulses on a symmetric trapezoidal period ramp while tracking position.
module stepper_move_ctrl #(
  parameter int unsigned START_DIV = 500000,
  parameter int unsigned MIN_DIV   = 50000,
  parameter int unsigned ACCEL_DEC = 25000,
  parameter int unsigned STEP_W    = 16
) (
  input  logic                CLK50MHZ,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [STEP_W-1:0]   cmd_steps,
  input  logic                cmd_dir,
  input  logic                abort,
  output logic                step,
  output logic                dir,
  output logic                busy,
  output logic                done,
  output logic signed [31:0]  position
);

  localparam logic [31:0] START_V = START_DIV;
  localparam logic [31:0] MIN_V   = MIN_DIV;
  localparam logic [31:0] ACCEL_V = ACCEL_DEC;

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [STEP_W-1:0]  remaining_q, remaining_d;
  logic [STEP_W-1:0]  ramp_q, ramp_d;
  logic [31:0]        cur_div_q, cur_div_d;
  logic [31:0]        tick_q, tick_d;
  logic               step_q, step_d;
  logic               dir_q, dir_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic signed [31:0] position_q, position_d;
  logic [STEP_W-1:0]  rem_next;

  // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    ramp_d      = ramp_q;
    cur_div_d   = cur_div_q;
    tick_d      = tick_q;
    dir_d       = dir_q;
    position_d  = position_q;
    step_d      = 1'b0;
    done_d      = 1'b0;
    rem_next    = remaining_q - STEP_W'(1);

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          dir_d = cmd_dir;
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = RUN;
            remaining_d = cmd_steps;
            cur_div_d   = START_V;
            ramp_d      = '0;
            tick_d      = '0;
          end
        end
      end

      RUN: begin
        // Abort takes priority over a step falling due in the same cycle.
        if (abort) begin
          state_d = IDLE;
          done_d  = 1'b1;
          tick_d  = '0;
        end else if (tick_q == cur_div_q - 32'd1) begin
          tick_d      = '0;
          step_d      = 1'b1;
          remaining_d = rem_next;
          position_d  = dir_q ? position_q + 32'sd1 : position_q - 32'sd1;
          if (rem_next == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (rem_next <= ramp_q) begin
            // Saturating forms compare the headroom first so the sum never wraps.
            cur_div_d = ((START_V - cur_div_q) <= ACCEL_V) ? START_V : cur_div_q + ACCEL_V;
            ramp_d    = (ramp_q == '0) ? '0 : ramp_q - STEP_W'(1);
          end else if (cur_div_q > MIN_V) begin
            cur_div_d = ((cur_div_q - MIN_V) <= ACCEL_V) ? MIN_V : cur_div_q - ACCEL_V;
            ramp_d    = ramp_q + STEP_W'(1);
          end
        end else begin
          tick_d = tick_q + 32'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d      = (state_d == RUN);
    cmd_ready_d = (state_d == IDLE) && !done_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK50MHZ) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      ramp_q      <= '0;
      cur_div_q   <= '0;
      tick_q      <= '0;
      step_q      <= 1'b0;
      dir_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      position_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      ramp_q      <= ramp_d;
      cur_div_q   <= cur_div_d;
      tick_q      <= tick_d;
      step_q      <= step_d;
      dir_q       <= dir_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
      position_q  <= position_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign step      = step_q;
  assign dir       = dir_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign position  = position_q;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Scoreboard bench for stepper_move_ctrl: the driver predicts each step/done event
// from a plain ramp model, and a negedge monitor pops and compares them.
module tb_stepper_move_ctrl;
  localparam int START_DIV = 10;
  localparam int MIN_DIV   = 4;
  localparam int ACCEL_DEC = 2;
  localparam int STEP_W    = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_dir = 1'b0;
  logic              abort = 1'b0;
  logic [STEP_W-1:0] cmd_steps = '0;
  logic              cmd_ready, step, dir, busy, done;
  logic [31:0]       position;

  stepper_move_ctrl #(
    .START_DIV(START_DIV), .MIN_DIV(MIN_DIV), .ACCEL_DEC(ACCEL_DEC), .STEP_W(STEP_W)
  ) dut (
    .CLK50MHZ(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .abort(abort), .step(step), .dir(dir),
    .busy(busy), .done(done), .position(position)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    bit          stp;
    bit          dn;
    bit          dr;
    logic [31:0] pos;
  } ev_t;

  ev_t sb[$];
  ev_t mon_ev;
  int  plan_q[$];
  int  n_checks = 0;
  int  n_pass = 0;
  int  pos_model = 0;
  bit  dir_model = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  // Step intervals of a move straight from the ramp rules.
  function automatic void make_plan(input int steps);
    int cur, ramp, rem;
    plan_q.delete();
    cur  = START_DIV;
    ramp = 0;
    rem  = steps;
    while (rem > 0) begin
      plan_q.push_back(cur);
      rem--;
      if (rem > 0) begin
        if (rem <= ramp) begin
          cur = (cur + ACCEL_DEC > START_DIV) ? START_DIV : cur + ACCEL_DEC;
          if (ramp > 0) ramp--;
        end else if (cur > MIN_DIV) begin
          cur = (cur - ACCEL_DEC < MIN_DIV) ? MIN_DIV : cur - ACCEL_DEC;
          ramp++;
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    if (step || done) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event: got step=%0b done=%0b at cycle %0d, expected no event",
                 step, done, cyc);
      end else begin
        mon_ev = sb.pop_front();
        check("event_cycle", cyc, mon_ev.at);
        check("step", step, mon_ev.stp);
        check("done", done, mon_ev.dn);
        check("busy", busy, !mon_ev.dn);
        check("cmd_ready_in_move", cmd_ready, 0);
        check("dir", dir, mon_ev.dr);
        check("position", position, mon_ev.pos);
      end
    end
  end

  task automatic cyc_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) cyc_step();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    cmd_valid = 1'b0;
    abort = 1'b0;
    repeat (n) cyc_step();
    sb.delete();
    pos_model = 0;
    dir_model = 1'b0;
    check("rst_step", step, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_position", position, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_dir", dir, 0);
    reset = 1'b0;
    cyc_step();
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_busy", busy, 0);
  endtask

  // Issue one command; abort_at = k aborts on the cycle step k would fire (0 = none).
  task automatic run_move(input int steps, input bit d, input int abort_at, input bit hold,
                          input bit idle_abort, input bit use_table);
    int a, t, last, abort_cyc, waited;
    cmd_steps = STEP_W'(steps);
    cmd_dir   = d;
    cmd_valid = 1'b1;
    abort     = idle_abort;
    waited    = 0;
    while (!cmd_ready && waited < 50) begin
      cyc_step();
      waited++;
    end
    if (!cmd_ready) begin
      n_checks++;
      $display("FAIL accept_timeout: got cmd_ready=0 for 50 cycles, expected 1");
      cmd_valid = 1'b0;
      abort = 1'b0;
      return;
    end
    a = cyc + 1;
    if (use_table) plan_q = '{10, 8, 6, 4, 6, 8};
    else make_plan(steps);
    dir_model = d;
    t = a;
    last = a;
    abort_cyc = 0;
    if (steps == 0) begin
      sb.push_back('{a, 1'b0, 1'b1, dir_model, pos_model});
    end else begin
      for (int k = 1; k <= steps; k++) begin
        t += plan_q[k-1];
        last = t;
        if (k == abort_at) begin
          abort_cyc = t;
          sb.push_back('{t, 1'b0, 1'b1, dir_model, pos_model});
          break;
        end
        pos_model += d ? 1 : -1;
        sb.push_back('{t, 1'b1, (k == steps), dir_model, pos_model});
      end
    end
    cyc_step();
    abort = 1'b0;
    if (!hold) cmd_valid = 1'b0;
    if (abort_cyc != 0) begin
      wait_until(abort_cyc - 1);
      abort = 1'b1;
      cyc_step();
      abort = 1'b0;
    end
    wait_until(last);
    cmd_valid = 1'b0;
    cyc_step();
    check("ready_after_done", cmd_ready, 1);
    check("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    int a, steps, abort_at;
    do_reset(3);

    run_move(6, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    run_move(20, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    run_move(0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    run_move(6, 1'b1, 3, 1'b0, 1'b0, 1'b0);
    run_move(5, 1'b0, 0, 1'b1, 1'b1, 1'b0);

    // Reset two steps into a held-valid move: nothing more may come out.
    cmd_steps = STEP_W'(6);
    cmd_dir   = 1'b1;
    cmd_valid = 1'b1;
    a = cyc + 1;
    sb.push_back('{a + 10, 1'b1, 1'b0, 1'b1, pos_model + 1});
    sb.push_back('{a + 18, 1'b1, 1'b0, 1'b1, pos_model + 2});
    wait_until(a + 19);
    do_reset(3);
    repeat (30) cyc_step();
    check("quiet_after_reset", sb.size(), 0);

    for (int i = 0; i < 25; i++) begin
      steps = $urandom_range(0, 24);
      abort_at = 0;
      if (steps > 0 && $urandom_range(0, 3) == 0) abort_at = $urandom_range(1, steps);
      run_move(steps, 1'($urandom_range(0, 1)), abort_at, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0), 1'b0);
      repeat ($urandom_range(0, 3)) cyc_step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
